rover_drive_ctrl: RTL and testbench
===================================

Name: rover_drive_ctrl

Overview:
- Parametrised two-motor drive controller for the rover's L298-style H-bridge.
- Inputs: inductive line-sensor vector, proximity stop, red-marker stop, direction request.
- Outputs: IN4..IN1 direction pins and PWM-modulated ENA/ENB enables.
- Adds what the fixed-pattern motor block lacked: PWM speed control, soft-start ramping, proximity/red braking, dead time on direction reversal, and input synchronisation.

Parameters:
- SENSE_BITS, 3: inductive sensor width. Must be odd and ≥3. Centre index C = SENSE_BITS/2.
- PWM_BITS, 8: PWM counter and duty width.
- DUTY_FAST, 200: target duty for the outer-wheel motor in a turn, and for both motors when going straight.
- DUTY_SLOW, 80: target duty for the inner-wheel motor in a turn.
- RAMP_STEP, 4: duty increment per ramp tick.
- RAMP_DIV, 1000: clock cycles per ramp tick.
- DEAD_CYCLES, 50: all-off cycles before (re)entering RUN.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: drive enable.
- dir, in, 1: 0 = forward, 1 = reverse.
- induct, in, SENSE_BITS: inductive sensors. Bits above C = left side; bits below C = right side.
- proxim, in, 1: obstacle present, active-high.
- red, in, 1: red marker seen, active-high.
- motor_in, out, 4: {IN4, IN3, IN2, IN1}. IN2:IN1 drive motor A (left); IN4:IN3 drive motor B (right).
- motor_en, out, 2: {ENB, ENA}, PWM.
- state, out, 3: encoded FSM state, for debug LEDs.

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values:
  - state = IDLE, motor_in = 0000, motor_en = 00.
  - duty_a = duty_b = 0, pwm_cnt = 0, ramp_cnt = 0, dead_cnt = 0.
- Input synchronisation: dir, induct, proxim and red pass through 2-flop synchronisers; enable is used directly.
  - A change on a synchronised input is acted on at the 3rd rising edge after it is applied.
- All outputs are decoded from registers only; there is no combinational input-to-output path.
- State encoding: IDLE = 0, RUN = 1, BRAKE = 2, DEAD = 3.
- Transition priority each edge: reset > !enable > (proxim | red) > dir change > normal.
- IDLE:
  - Outputs all 0; duties cleared.
  - Leaves to DEAD when enable = 1; dead_cnt loads 0 and dir is latched as cur_dir.
- DEAD:
  - motor_in = 0000, motor_en = 00, duties held at 0.
  - dead_cnt increments each cycle; enters RUN on the edge where dead_cnt == DEAD_CYCLES-1.
  - If proxim | red is asserted, goes to BRAKE.
- RUN:
  - Forward (cur_dir = 0): motor_in = 0101. Reverse: motor_in = 1010.
  - ENA = (pwm_cnt < duty_a); ENB = (pwm_cnt < duty_b).
  - If sync dir != cur_dir: go to DEAD, clear duties, latch the new dir.
  - If proxim | red: go to BRAKE.
- BRAKE:
  - motor_in = 1111, motor_en = 11 (fast stop); duties cleared to 0.
  - Stays while proxim | red. When both are clear, goes to DEAD (dead_cnt = 0).
- Target duties, evaluated in RUN only:
  - Straight (centre bit set, or left-side and right-side bit counts equal and nonzero): tgt_a = tgt_b = DUTY_FAST.
  - Left count > right count (line to the left): tgt_a = DUTY_SLOW, tgt_b = DUTY_FAST.
  - Right count > left count: tgt_a = DUTY_FAST, tgt_b = DUTY_SLOW.
  - induct == 0 (line lost): tgt_a = tgt_b = 0.
- Ramp:
  - ramp_cnt counts 0..RAMP_DIV-1 and wraps; a tick occurs on wrap.
  - On each tick, each duty moves toward its target by RAMP_STEP (up or down), saturating exactly at the target with no overshoot.
  - ramp_cnt runs only in RUN; it is cleared on entering RUN.
- PWM:
  - pwm_cnt is free-running, 0..2^PWM_BITS-1, and wraps to 0.
  - Duty 0 means the enable is never high; the maximum high fraction is (2^PWM_BITS-1)/2^PWM_BITS.
- Arithmetic: duties are PWM_BITS wide. Ramp math is done at PWM_BITS+1 bits and clamped to the target.
- enable deasserted mid-RUN, BRAKE or DEAD: IDLE on the next edge; outputs go to 0 that cycle.
- reset mid-operation: all registers return to reset values on that edge.

Test Plan:
- Bench parameters for all scenarios: PWM_BITS=4, DUTY_FAST=12, DUTY_SLOW=4, RAMP_STEP=4, RAMP_DIV=2, DEAD_CYCLES=3.
- Start-up: reset, then enable=1, induct=010, dir=0.
  - Expect DEAD for 3 cycles with outputs 0, then RUN with motor_in=0101.
  - duty_a = duty_b step 0→4→8→12 every 2 cycles, then hold.
  - ENA is high for 12 of 16 cycles.
- Steering: in steady RUN, set induct=100.
  - After sync delay, duty_a ramps 12→8→4 and stops at 4; duty_b stays 12.
  - Then set induct=001: duty_a ramps back to 12 and duty_b ramps down to 4.
- Obstacle: in RUN, pulse proxim high for 10 cycles.
  - BRAKE (motor_in=1111, motor_en=11) starts 3 edges after assertion and holds until proxim is clear plus sync delay.
  - Then 3 DEAD cycles, then RUN with the ramp restarting from 0.
- Reversal: in RUN at full duty, toggle dir=1.
  - Expect DEAD for 3 cycles with all outputs 0.
  - Then RUN with motor_in=1010 and duties ramping from 0.
- Priority and reset:
  - Assert red and toggle dir on the same cycle → BRAKE, not DEAD.
  - Drop enable during BRAKE → IDLE next edge.
  - Assert reset mid-ramp → all outputs 0 and state=0 on that edge.
- Line lost: induct=000 in RUN → both duties ramp to 0 and motor_en stays 00; motor_in remains 0101.

Source files
------------

// File: rtl/rover_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rover_drive_ctrl
//  Brief    : Two-motor H-bridge drive controller with PWM speed control,
//             soft-start ramping, proximity/red braking, direction-reversal
//             dead time and input synchronisation.
//  Revision : 1.0 - initial release
// ============================================================================
module rover_drive_ctrl #(
    parameter int SENSE_BITS  = 3,
    parameter int PWM_BITS    = 8,
    parameter int DUTY_FAST   = 200,
    parameter int DUTY_SLOW   = 80,
    parameter int RAMP_STEP   = 4,
    parameter int RAMP_DIV    = 1000,
    parameter int DEAD_CYCLES = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  dir,
    input  logic [SENSE_BITS-1:0] induct,
    input  logic                  proxim,
    input  logic                  red,
    output logic [3:0]            motor_in,
    output logic [1:0]            motor_en,
    output logic [2:0]            state
);

    localparam int c_centre = SENSE_BITS / 2;
    localparam int c_cnt_w  = $clog2(SENSE_BITS + 1);
    localparam int c_ramp_w = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int c_dead_w = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [PWM_BITS-1:0] c_duty_fast = DUTY_FAST[PWM_BITS-1:0];
    localparam logic [PWM_BITS-1:0] c_duty_slow = DUTY_SLOW[PWM_BITS-1:0];
    localparam logic [PWM_BITS:0]   c_step      = RAMP_STEP[PWM_BITS:0];
    localparam logic [c_ramp_w-1:0] c_ramp_last = c_ramp_w'(RAMP_DIV - 1);
    localparam logic [c_dead_w-1:0] c_dead_last = c_dead_w'(DEAD_CYCLES - 1);

    typedef enum logic [2:0] {
        c_st_idle  = 3'd0,
        c_st_run   = 3'd1,
        c_st_brake = 3'd2,
        c_st_dead  = 3'd3
    } state_t;

    state_t                r_state;
    logic [3:0]            r_motor_in;
    logic [1:0]            r_motor_en;
    logic                  r_cur_dir;
    logic [PWM_BITS-1:0]   r_duty_a;
    logic [PWM_BITS-1:0]   r_duty_b;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [c_ramp_w-1:0]   r_ramp_cnt;
    logic [c_dead_w-1:0]   r_dead_cnt;

    logic                  r_dir_s1, r_dir_s2;
    logic [SENSE_BITS-1:0] r_induct_s1, r_induct_s2;
    logic                  r_prox_s1, r_prox_s2;
    logic                  r_red_s1, r_red_s2;

    logic [c_cnt_w-1:0]    w_left_cnt;
    logic [c_cnt_w-1:0]    w_right_cnt;
    logic [PWM_BITS-1:0]   w_tgt_a;
    logic [PWM_BITS-1:0]   w_tgt_b;
    logic                  w_stop;

    assign w_stop   = r_prox_s2 | r_red_s2;
    assign motor_in = r_motor_in;
    assign motor_en = r_motor_en;
    assign state    = r_state;

    // Step a duty one ramp increment toward its target, landing exactly on it
    function automatic logic [PWM_BITS-1:0] f_ramp(input logic [PWM_BITS-1:0] cur,
                                                   input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS:0] w_cur;
        logic [PWM_BITS:0] w_tg;
        w_cur = {1'b0, cur};
        w_tg  = {1'b0, tgt};
        if (w_cur < w_tg) begin
            if (w_cur + c_step >= w_tg) return tgt;
            return cur + c_step[PWM_BITS-1:0];
        end else if (w_cur > w_tg) begin
            if (w_cur - w_tg <= c_step) return tgt;
            return cur - c_step[PWM_BITS-1:0];
        end
        return cur;
    endfunction

    // Two-flop synchronisers for the asynchronous sensor and direction inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir_s1    <= 1'b0;
            r_dir_s2    <= 1'b0;
            r_induct_s1 <= '0;
            r_induct_s2 <= '0;
            r_prox_s1   <= 1'b0;
            r_prox_s2   <= 1'b0;
            r_red_s1    <= 1'b0;
            r_red_s2    <= 1'b0;
        end else begin
            r_dir_s1    <= dir;
            r_dir_s2    <= r_dir_s1;
            r_induct_s1 <= induct;
            r_induct_s2 <= r_induct_s1;
            r_prox_s1   <= proxim;
            r_prox_s2   <= r_prox_s1;
            r_red_s1    <= red;
            r_red_s2    <= r_red_s1;
        end
    end

    // Count active sensors on each side of the centre sensor
    always_comb begin
        w_left_cnt  = '0;
        w_right_cnt = '0;
        for (int i = 0; i < SENSE_BITS; i++) begin
            if (i > c_centre)
                w_left_cnt = w_left_cnt + c_cnt_w'(r_induct_s2[i]);
            else if (i < c_centre)
                w_right_cnt = w_right_cnt + c_cnt_w'(r_induct_s2[i]);
        end
    end

    // Steering targets: slow the wheel on the side the line has drifted to
    always_comb begin
        w_tgt_a = '0;
        w_tgt_b = '0;
        if (r_induct_s2 == '0) begin
            w_tgt_a = '0;
            w_tgt_b = '0;
        end else if (r_induct_s2[c_centre] || (w_left_cnt == w_right_cnt)) begin
            w_tgt_a = c_duty_fast;
            w_tgt_b = c_duty_fast;
        end else if (w_left_cnt > w_right_cnt) begin
            w_tgt_a = c_duty_slow;
            w_tgt_b = c_duty_fast;
        end else begin
            w_tgt_a = c_duty_fast;
            w_tgt_b = c_duty_slow;
        end
    end

    // Drive FSM with registered bridge outputs, ramp and dead-time counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_motor_in <= 4'b0000;
            r_motor_en <= 2'b00;
            r_cur_dir  <= 1'b0;
            r_duty_a   <= '0;
            r_duty_b   <= '0;
            r_pwm_cnt  <= '0;
            r_ramp_cnt <= '0;
            r_dead_cnt <= '0;
        end else begin
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            r_ramp_cnt <= '0;
            if ((r_state != c_st_idle) && !enable) begin
                r_state    <= c_st_idle;
                r_motor_in <= 4'b0000;
                r_motor_en <= 2'b00;
                r_duty_a   <= '0;
                r_duty_b   <= '0;
                r_dead_cnt <= '0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        r_motor_in <= 4'b0000;
                        r_motor_en <= 2'b00;
                        r_duty_a   <= '0;
                        r_duty_b   <= '0;
                        if (enable) begin
                            r_state    <= c_st_dead;
                            r_dead_cnt <= '0;
                            r_cur_dir  <= r_dir_s2;
                        end
                    end
                    c_st_dead: begin
                        r_duty_a <= '0;
                        r_duty_b <= '0;
                        if (w_stop) begin
                            r_state    <= c_st_brake;
                            r_motor_in <= 4'b1111;
                            r_motor_en <= 2'b11;
                        end else if (r_dead_cnt == c_dead_last) begin
                            r_state    <= c_st_run;
                            r_motor_in <= r_cur_dir ? 4'b1010 : 4'b0101;
                            r_motor_en <= 2'b00;
                        end else begin
                            r_dead_cnt <= r_dead_cnt + 1'b1;
                            r_motor_in <= 4'b0000;
                            r_motor_en <= 2'b00;
                        end
                    end
                    c_st_run: begin
                        if (w_stop) begin
                            r_state    <= c_st_brake;
                            r_motor_in <= 4'b1111;
                            r_motor_en <= 2'b11;
                            r_duty_a   <= '0;
                            r_duty_b   <= '0;
                        end else if (r_dir_s2 != r_cur_dir) begin
                            r_state    <= c_st_dead;
                            r_motor_in <= 4'b0000;
                            r_motor_en <= 2'b00;
                            r_duty_a   <= '0;
                            r_duty_b   <= '0;
                            r_dead_cnt <= '0;
                            r_cur_dir  <= r_dir_s2;
                        end else begin
                            r_motor_in <= r_cur_dir ? 4'b1010 : 4'b0101;
                            r_motor_en <= {(r_pwm_cnt < r_duty_b), (r_pwm_cnt < r_duty_a)};
                            if (r_ramp_cnt == c_ramp_last) begin
                                r_duty_a <= f_ramp(r_duty_a, w_tgt_a);
                                r_duty_b <= f_ramp(r_duty_b, w_tgt_b);
                            end else begin
                                r_ramp_cnt <= r_ramp_cnt + 1'b1;
                            end
                        end
                    end
                    c_st_brake: begin
                        r_duty_a <= '0;
                        r_duty_b <= '0;
                        if (w_stop) begin
                            r_motor_in <= 4'b1111;
                            r_motor_en <= 2'b11;
                        end else begin
                            r_state    <= c_st_dead;
                            r_motor_in <= 4'b0000;
                            r_motor_en <= 2'b00;
                            r_dead_cnt <= '0;
                            r_cur_dir  <= r_dir_s2;
                        end
                    end
                    default: begin
                        r_state    <= c_st_idle;
                        r_motor_in <= 4'b0000;
                        r_motor_en <= 2'b00;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rover_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rover_drive_ctrl
//  Brief    : Directed self-checking bench for rover_drive_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rover_drive_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       dir;
    logic [2:0] induct;
    logic       proxim;
    logic       red;
    logic [3:0] motor_in;
    logic [1:0] motor_en;
    logic [2:0] state;

    int n_pass;
    int n_total;

    rover_drive_ctrl #(
        .SENSE_BITS (3),
        .PWM_BITS   (4),
        .DUTY_FAST  (12),
        .DUTY_SLOW  (4),
        .RAMP_STEP  (4),
        .RAMP_DIV   (2),
        .DEAD_CYCLES(3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .dir     (dir),
        .induct  (induct),
        .proxim  (proxim),
        .red     (red),
        .motor_in(motor_in),
        .motor_en(motor_en),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; dir = 1'b0; induct = 3'b000; proxim = 1'b0; red = 1'b0;
        ticks(3);
        n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_total++; if (motor_in !== 4'b0000) $display("FAIL reset_motor_in: got %b want 0000", motor_in); else n_pass++;
        n_total++; if (motor_en !== 2'b00) $display("FAIL reset_motor_en: got %b want 00", motor_en); else n_pass++;
        n_total++; if (dut.r_duty_a !== 4'd0 || dut.r_duty_b !== 4'd0)
            $display("FAIL reset_duty: got %0d/%0d want 0/0", dut.r_duty_a, dut.r_duty_b); else n_pass++;
        n_total++; if (dut.r_pwm_cnt !== 4'd0) $display("FAIL reset_pwm_cnt: got %0d want 0", dut.r_pwm_cnt); else n_pass++;
        reset = 1'b0;
        induct = 3'b010;
        ticks(3);
        n_total++; if (state !== 3'd0) $display("FAIL idle_hold: got %0d want 0", state); else n_pass++;
    endtask

    task automatic test_startup();
        int ena_hi;
        int enb_hi;
        int exp_d;
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_total++; if (state !== 3'd3 || motor_in !== 4'b0000 || motor_en !== 2'b00)
                $display("FAIL startup_dead[%0d]: got st=%0d in=%b en=%b want st=3 in=0000 en=00", i, state, motor_in, motor_en);
            else n_pass++;
        end
        tick();
        n_total++; if (state !== 3'd1 || motor_in !== 4'b0101)
            $display("FAIL startup_run: got st=%0d in=%b want st=1 in=0101", state, motor_in); else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_d = 4 * ((k / 2 > 3) ? 3 : k / 2);
            n_total++; if (dut.r_duty_a !== 4'(exp_d) || dut.r_duty_b !== 4'(exp_d))
                $display("FAIL startup_ramp[%0d]: got %0d/%0d want %0d/%0d", k, dut.r_duty_a, dut.r_duty_b, exp_d, exp_d);
            else n_pass++;
        end
        ena_hi = 0;
        enb_hi = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            ena_hi += int'(motor_en[0]);
            enb_hi += int'(motor_en[1]);
        end
        n_total++; if (ena_hi != 12) $display("FAIL startup_ena_duty: got %0d want 12 of 16", ena_hi); else n_pass++;
        n_total++; if (enb_hi != 12) $display("FAIL startup_enb_duty: got %0d want 12 of 16", enb_hi); else n_pass++;
    endtask

    task automatic test_steering();
        bit seen_a8;
        bit seen_b8;
        bit b_moved;
        int min_a;
        induct = 3'b100;
        ticks(2);
        n_total++; if (dut.r_duty_a !== 4'd12) $display("FAIL steer_sync_delay: got %0d want 12", dut.r_duty_a); else n_pass++;
        seen_a8 = 0; b_moved = 0; min_a = 15;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dut.r_duty_a == 4'd8) seen_a8 = 1;
            if (int'(dut.r_duty_a) < min_a) min_a = int'(dut.r_duty_a);
            if (dut.r_duty_b != 4'd12) b_moved = 1;
        end
        n_total++; if (dut.r_duty_a !== 4'd4) $display("FAIL steer_left_a: got %0d want 4", dut.r_duty_a); else n_pass++;
        n_total++; if (!seen_a8) $display("FAIL steer_left_step: got seen8=0 want seen8=1"); else n_pass++;
        n_total++; if (min_a != 4) $display("FAIL steer_left_overshoot: got min %0d want 4", min_a); else n_pass++;
        n_total++; if (b_moved) $display("FAIL steer_left_b: got moved=1 want duty_b fixed at 12"); else n_pass++;

        induct = 3'b001;
        seen_a8 = 0; seen_b8 = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (dut.r_duty_a == 4'd8) seen_a8 = 1;
            if (dut.r_duty_b == 4'd8) seen_b8 = 1;
        end
        n_total++; if (dut.r_duty_a !== 4'd12 || dut.r_duty_b !== 4'd4)
            $display("FAIL steer_right: got %0d/%0d want 12/4", dut.r_duty_a, dut.r_duty_b); else n_pass++;
        n_total++; if (!seen_a8 || !seen_b8)
            $display("FAIL steer_right_step: got seen8 a=%0d b=%0d want 1/1", seen_a8, seen_b8); else n_pass++;
        n_total++; if (motor_in !== 4'b0101) $display("FAIL steer_motor_in: got %b want 0101", motor_in); else n_pass++;
    endtask

    task automatic test_obstacle();
        proxim = 1'b1;
        ticks(2);
        n_total++; if (state !== 3'd1) $display("FAIL obst_sync_delay: got st=%0d want 1", state); else n_pass++;
        for (int i = 3; i <= 10; i++) begin
            tick();
            n_total++; if (state !== 3'd2 || motor_in !== 4'b1111 || motor_en !== 2'b11)
                $display("FAIL obst_brake[%0d]: got st=%0d in=%b en=%b want st=2 in=1111 en=11", i, state, motor_in, motor_en);
            else n_pass++;
        end
        proxim = 1'b0;
        ticks(2);
        n_total++; if (state !== 3'd2 || dut.r_duty_a !== 4'd0)
            $display("FAIL obst_brake_hold: got st=%0d duty=%0d want st=2 duty=0", state, dut.r_duty_a); else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_total++; if (state !== 3'd3 || motor_in !== 4'b0000 || motor_en !== 2'b00)
                $display("FAIL obst_dead[%0d]: got st=%0d in=%b en=%b want st=3 in=0000 en=00", i, state, motor_in, motor_en);
            else n_pass++;
        end
        tick();
        n_total++; if (state !== 3'd1 || dut.r_duty_a !== 4'd0)
            $display("FAIL obst_rerun: got st=%0d duty=%0d want st=1 duty=0", state, dut.r_duty_a); else n_pass++;
        ticks(2);
        n_total++; if (dut.r_duty_a !== 4'd4) $display("FAIL obst_ramp_restart: got %0d want 4", dut.r_duty_a); else n_pass++;
    endtask

    task automatic test_reversal();
        induct = 3'b010;
        ticks(14);
        n_total++; if (dut.r_duty_a !== 4'd12 || dut.r_duty_b !== 4'd12)
            $display("FAIL rev_full_duty: got %0d/%0d want 12/12", dut.r_duty_a, dut.r_duty_b); else n_pass++;
        dir = 1'b1;
        ticks(2);
        n_total++; if (state !== 3'd1 || motor_in !== 4'b0101)
            $display("FAIL rev_sync_delay: got st=%0d in=%b want st=1 in=0101", state, motor_in); else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_total++; if (state !== 3'd3 || motor_in !== 4'b0000 || motor_en !== 2'b00)
                $display("FAIL rev_dead[%0d]: got st=%0d in=%b en=%b want st=3 in=0000 en=00", i, state, motor_in, motor_en);
            else n_pass++;
        end
        tick();
        n_total++; if (state !== 3'd1 || motor_in !== 4'b1010 || dut.r_duty_a !== 4'd0)
            $display("FAIL rev_run: got st=%0d in=%b duty=%0d want st=1 in=1010 duty=0", state, motor_in, dut.r_duty_a);
        else n_pass++;
        ticks(2);
        n_total++; if (dut.r_duty_a !== 4'd4 || dut.r_duty_b !== 4'd4)
            $display("FAIL rev_ramp: got %0d/%0d want 4/4", dut.r_duty_a, dut.r_duty_b); else n_pass++;
    endtask

    task automatic test_priority();
        red = 1'b1;
        dir = 1'b0;
        ticks(3);
        n_total++; if (state !== 3'd2 || motor_in !== 4'b1111)
            $display("FAIL prio_brake_over_dead: got st=%0d in=%b want st=2 in=1111", state, motor_in); else n_pass++;
        tick();
        n_total++; if (state !== 3'd2) $display("FAIL prio_brake_hold: got st=%0d want 2", state); else n_pass++;
        enable = 1'b0;
        tick();
        n_total++; if (state !== 3'd0 || motor_in !== 4'b0000 || motor_en !== 2'b00)
            $display("FAIL prio_disable: got st=%0d in=%b en=%b want st=0 in=0000 en=00", state, motor_in, motor_en);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        red = 1'b0;
        ticks(3);
        enable = 1'b1;
        ticks(6);
        n_total++; if (state !== 3'd1 || dut.r_duty_a !== 4'd4)
            $display("FAIL midreset_pre: got st=%0d duty=%0d want st=1 duty=4", state, dut.r_duty_a); else n_pass++;
        reset = 1'b1;
        tick();
        n_total++; if (state !== 3'd0 || motor_in !== 4'b0000 || motor_en !== 2'b00)
            $display("FAIL midreset_out: got st=%0d in=%b en=%b want st=0 in=0000 en=00", state, motor_in, motor_en);
        else n_pass++;
        n_total++; if (dut.r_duty_a !== 4'd0 || dut.r_pwm_cnt !== 4'd0 || dut.r_ramp_cnt !== 1'b0)
            $display("FAIL midreset_regs: got duty=%0d pwm=%0d ramp=%0d want 0/0/0", dut.r_duty_a, dut.r_pwm_cnt, dut.r_ramp_cnt);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_line_lost();
        bit en_seen;
        bit in_bad;
        ticks(14);
        n_total++; if (state !== 3'd1 || dut.r_duty_a !== 4'd12 || dut.r_duty_b !== 4'd12)
            $display("FAIL lost_pre: got st=%0d duty=%0d/%0d want st=1 12/12", state, dut.r_duty_a, dut.r_duty_b);
        else n_pass++;
        induct = 3'b000;
        ticks(12);
        n_total++; if (dut.r_duty_a !== 4'd0 || dut.r_duty_b !== 4'd0)
            $display("FAIL lost_duty: got %0d/%0d want 0/0", dut.r_duty_a, dut.r_duty_b); else n_pass++;
        en_seen = 0; in_bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (motor_en != 2'b00) en_seen = 1;
            if (motor_in != 4'b0101 || state != 3'd1) in_bad = 1;
        end
        n_total++; if (en_seen) $display("FAIL lost_motor_en: got nonzero enable want 00"); else n_pass++;
        n_total++; if (in_bad) $display("FAIL lost_motor_in: got change want in=0101 st=1 throughout"); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset = 1'b1; enable = 1'b0; dir = 1'b0; induct = 3'b000; proxim = 1'b0; red = 1'b0;
        test_reset();
        test_startup();
        test_steering();
        test_obstacle();
        test_reversal();
        test_priority();
        test_reset_mid();
        test_line_lost();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
